// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, valid/ready on both sides.
// Optional ASCII digit output enabled by defining BCD_ASCII_OUT_EN.
module bin_to_bcd_seq #(
    parameter int BIN_W      = 11,
    parameter int BCD_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_W-1:0]        in_bin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*BCD_DIGITS-1:0] out_bcd,
`ifdef BCD_ASCII_OUT_EN
    output logic [8*BCD_DIGITS-1:0] out_ascii,
`endif
    output logic                    out_ovf
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [63:0] BCD_LIMIT = 64'(10 ** BCD_DIGITS);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                   state, state_nxt;
    logic [BCD_W-1:0]         bcd;
    logic [BIN_W-1:0]         bin;
    logic [CNT_W-1:0]         cnt;
    logic [BCD_W+BIN_W-1:0]   shifted;
    logic                     accept;
    logic                     last_shift;

    function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (r[4*d +: 4] >= 4'd5)
                r[4*d +: 4] = r[4*d +: 4] + 4'd3;
        end
        return r;
    endfunction

`ifdef BCD_ASCII_OUT_EN
    function automatic logic [8*BCD_DIGITS-1:0] to_ascii(input logic [BCD_W-1:0] v);
        logic [8*BCD_DIGITS-1:0] r;
        for (int d = 0; d < BCD_DIGITS; d++)
            r[8*d +: 8] = {4'h3, v[4*d +: 4]};
        return r;
    endfunction
`endif

    // The MSB of the combined register falls off the top nibble; out_ovf accounts for it.
    assign shifted    = {add3_adjust(bcd), bin} << 1;
    assign accept     = (state == IDLE) && in_valid && in_ready;
    assign last_shift = (state == SHIFT) && (cnt == CNT_W'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // in_ready is registered so it stays low through reset and rises one edge after release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_ovf   <= 1'b0;
            bcd       <= '0;
            bin       <= '0;
            cnt       <= '0;
`ifdef BCD_ASCII_OUT_EN
            out_ascii <= {BCD_DIGITS{8'h30}};
`endif
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            if (accept) begin
                bin     <= in_bin;
                bcd     <= '0;
                cnt     <= CNT_W'(BIN_W);
                out_ovf <= (64'(in_bin) >= BCD_LIMIT);
            end
            if (state == SHIFT) begin
                {bcd, bin} <= shifted;
                cnt        <= cnt - CNT_W'(1);
                if (last_shift) begin
                    out_bcd <= shifted[BCD_W+BIN_W-1 -: BCD_W];
`ifdef BCD_ASCII_OUT_EN
                    out_ascii <= to_ascii(shifted[BCD_W+BIN_W-1 -: BCD_W]);
`endif
                end
            end
        end
    end

endmodule
